// File: rtl/osc_freq_monitor_pkg.sv
// Shared types and sizing helpers for the oscillator frequency monitor.
package osc_freq_monitor_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, EVAL} state_t;

  localparam int COUNT_W = 16;
  localparam int FAIL_W  = 4;

  // Width that holds window-counter values 0..cycles-1.
  function automatic int win_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/osc_mon_edge_sync.sv
// Brings the asynchronous monitored clock into gclk and flags its rising edges.
module osc_mon_edge_sync (
  input  logic gclk,
  input  logic grst_n,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync;
  logic       hist;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[0], async_in};
      hist <= sync[1];
    end
  end

  assign rise = sync[1] & ~hist;

endmodule

// File: rtl/osc_freq_monitor.sv
// Counts MON_CLK rising edges per reference window and flags out-of-range or dead oscillators.
// Optional dead-clock detection is built when OSC_FREQ_MONITOR_STUCK_DETECT_EN is defined.
module osc_freq_monitor
  import osc_freq_monitor_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50000,
  parameter int MIN_COUNT     = 950,
  parameter int MAX_COUNT     = 1050,
  parameter int FAIL_LIMIT    = 2,
  parameter int STUCK_CYCLES  = 256
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               MON_CLK,
  input  logic               ENABLE,
  input  logic               ALARM_CLR,
  output logic [COUNT_W-1:0] COUNT,
  output logic               COUNT_VALID,
  output logic               FREQ_OK,
  output logic               ALARM
);

  localparam int                 WIN_W    = win_cnt_w(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MIN  = COUNT_W'(MIN_COUNT);
  localparam logic [COUNT_W-1:0] CNT_MAX  = COUNT_W'(MAX_COUNT);
  localparam logic [FAIL_W-1:0]  FAIL_LIM = FAIL_W'(FAIL_LIMIT);

  if (FAIL_LIMIT < 1 || FAIL_LIMIT > 15 || STUCK_CYCLES < 1 || WINDOW_CYCLES < 1) begin : g_bad_cfg
    $error("osc_freq_monitor: invalid parameter set");
  end

  state_t             state;
  logic [WIN_W-1:0]   win_cnt;
  logic [COUNT_W-1:0] edge_cnt, edge_nxt;
  logic [FAIL_W-1:0]  fail_cnt, fail_inc;
  logic               rise, in_range, eval_bad, alarm_hit, stuck_hit, stuck_r;

  osc_mon_edge_sync u_sync (
    .gclk     (CLK),
    .grst_n   (RESETN),
    .async_in (MON_CLK),
    .rise     (rise)
  );

  assign edge_nxt  = (rise && edge_cnt != '1) ? edge_cnt + 1'b1 : edge_cnt;
  assign in_range  = (edge_cnt >= CNT_MIN) && (edge_cnt <= CNT_MAX);
  assign fail_inc  = (fail_cnt == '1) ? fail_cnt : fail_cnt + 1'b1;
  assign eval_bad  = (state == EVAL) && (!in_range || stuck_r);
  // A dead clock raises the alarm on its own; otherwise the streak must reach the limit.
  assign alarm_hit = eval_bad && (stuck_r || fail_inc >= FAIL_LIM);

`ifdef OSC_FREQ_MONITOR_STUCK_DETECT_EN
  localparam int IDLE_W = ($clog2(STUCK_CYCLES + 1) > 8) ? $clog2(STUCK_CYCLES + 1) : 8;
  logic [IDLE_W-1:0] idle_cnt;

  assign stuck_hit = (state == MEASURE) && ENABLE && !rise &&
                     (idle_cnt == IDLE_W'(STUCK_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      idle_cnt <= '0;
      stuck_r  <= 1'b0;
    end else begin
      if (state != MEASURE || rise) idle_cnt <= '0;
      else                          idle_cnt <= idle_cnt + 1'b1;
      if (stuck_hit)                stuck_r  <= 1'b1;
      else if (state == EVAL)       stuck_r  <= 1'b0;
    end
  end
`else
  assign stuck_hit = 1'b0;
  assign stuck_r   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state       <= IDLE;
      win_cnt     <= '0;
      edge_cnt    <= '0;
      fail_cnt    <= '0;
      COUNT       <= '0;
      COUNT_VALID <= 1'b0;
      FREQ_OK     <= 1'b0;
      ALARM       <= 1'b0;
    end else begin
      COUNT_VALID <= 1'b0;
      case (state)
        IDLE: begin
          win_cnt  <= '0;
          edge_cnt <= '0;
          if (ENABLE) state <= MEASURE;
        end
        MEASURE: begin
          if (!ENABLE) begin
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            win_cnt  <= win_cnt + 1'b1;
            edge_cnt <= edge_nxt;
            if (win_cnt == WIN_LAST || stuck_hit) state <= EVAL;
          end
        end
        EVAL: begin
          COUNT       <= edge_cnt;
          COUNT_VALID <= 1'b1;
          FREQ_OK     <= in_range && !stuck_r;
          win_cnt     <= '0;
          edge_cnt    <= '0;
          state       <= ENABLE ? MEASURE : IDLE;
        end
        default: state <= IDLE;
      endcase

      // A clear landing on an ordinary bad window still leaves that window counted.
      if (state == EVAL) begin
        if (!eval_bad)                   fail_cnt <= '0;
        else if (alarm_hit || !ALARM_CLR) fail_cnt <= fail_inc;
        else                             fail_cnt <= FAIL_W'(1);
      end else if (ALARM_CLR) begin
        fail_cnt <= '0;
      end

      if (alarm_hit)      ALARM <= 1'b1;
      else if (ALARM_CLR) ALARM <= 1'b0;
    end
  end

endmodule

// File: doc/osc_freq_monitor.md
# osc_freq_monitor

Fabric-side frequency monitor for the on-chip oscillators. It runs on the 50 MHz RC oscillator fabric clock, samples a slower oscillator output (nominally the 1 MHz RC oscillator fabric output) as a data signal, and counts its rising edges over a fixed reference window. It flags out-of-range or dead oscillators to the system controller through a per-window count strobe, a live frequency-good flag and a sticky alarm.

## Interface
Parameters:
- WINDOW_CYCLES, 50000, reference-clock cycles per measurement window (1 ms at 50 MHz).
- MIN_COUNT, 950, lowest in-range edge count, inclusive.
- MAX_COUNT, 1050, highest in-range edge count, inclusive.
- FAIL_LIMIT, 2, consecutive out-of-range windows required to set ALARM (1..15).
- STUCK_CYCLES, 256, edge-free reference cycles that count as a dead clock; used only with the stuck-detect macro.

Ports:
- CLK, input, 1, 50 MHz fabric clock from the RC oscillator.
- RESETN, input, 1, asynchronous active-low reset.
- MON_CLK, input, 1, monitored oscillator output, asynchronous to CLK; must be below CLK/4.
- ENABLE, input, 1, level; 1 runs back-to-back measurement windows.
- ALARM_CLR, input, 1, single-cycle pulse that clears ALARM and the fail counter.
- COUNT, output, 16, edge count of the last completed window, saturating at 16'hFFFF.
- COUNT_VALID, output, 1, one-cycle strobe when COUNT updates.
- FREQ_OK, output, 1, 1 when the last window was in range.
- ALARM, output, 1, sticky out-of-range/dead-clock flag.

## Operation
- MON_CLK passes through a 2-flop synchronizer and then one history flop. A rising edge is detected when the synchronized value is 1 and the history value is 0.
- States:
  - IDLE: counters held at 0. Moves to MEASURE on ENABLE=1.
  - MEASURE: the window counter runs 0..WINDOW_CYCLES-1, and the edge counter increments on each detected edge, saturating at 16'hFFFF. An edge detected on the terminal cycle is counted. The state moves to EVAL after the terminal cycle.
  - EVAL: one cycle. Loads COUNT, pulses COUNT_VALID and sets FREQ_OK = (MIN_COUNT ≤ count ≤ MAX_COUNT).
- Fail counter (4 bits, saturating):
  - Increments on each out-of-range EVAL and clears on each in-range EVAL.
  - ALARM sets when the fail counter reaches FAIL_LIMIT.
- After EVAL, the block returns to MEASURE if ENABLE=1, otherwise to IDLE. Counters restart from 0.
- ENABLE dropping during MEASURE aborts the window: the block goes to IDLE with no COUNT_VALID, and COUNT/FREQ_OK/ALARM keep their values.
- When ALARM_CLR coincides with an alarm-setting event, the set wins. When it coincides with an ordinary out-of-range EVAL, the fail counter ends at 1.

## Timing
- Reset values: COUNT=0, COUNT_VALID=0, FREQ_OK=0, ALARM=0, state IDLE, all counters 0.
- Detection latency from a MON_CLK rising edge to the edge counter increment: 3 CLK cycles.
- Window: WINDOW_CYCLES cycles of MEASURE plus 1 cycle of EVAL. The window period is WINDOW_CYCLES+1 cycles, so 50001 at the defaults.
- COUNT, FREQ_OK and COUNT_VALID all change on the same edge, the one registered in EVAL.
- ALARM rises on that same edge when the limit is reached.
- RESETN asserted mid-window returns every output to its reset value asynchronously. The first window after release starts on the first cycle with ENABLE=1.

## Configuration
- Macro: OSC_FREQ_MONITOR_STUCK_DETECT_EN.
- Defined:
  - An 8+-bit idle counter clears on every detected edge and on entry to MEASURE.
  - When it reaches STUCK_CYCLES in MEASURE, the block sets ALARM immediately, forces FREQ_OK=0 and goes to EVAL early. The early EVAL loads COUNT with the partial count and pulses COUNT_VALID.
- Not defined: no idle counter exists, and a dead clock is reported only at the window end as count 0.

## Structure
- Shared package osc_freq_monitor_pkg holds:
  - the state enum (IDLE, MEASURE, EVAL);
  - COUNT_W=16 and FAIL_W=4;
  - a function returning the window-counter width for WINDOW_CYCLES.
- One sub-module, osc_mon_edge_sync, contains the 2-flop synchronizer, the history flop and the rising-edge pulse output. It resets to 0.

## Test plan
- MON_CLK at 1 MHz (period 50 CLK), ENABLE=1 → COUNT_VALID every 50001 cycles, COUNT of 1000 or 1001, FREQ_OK=1, ALARM=0.
- MON_CLK at 1.1 MHz → COUNT≈1100, FREQ_OK=0 after window 1, ALARM=1 on the window-2 COUNT_VALID edge. ALARM_CLR pulse → ALARM=0.
- Window 1 out of range, window 2 in range, window 3 out of range → ALARM stays 0 (fail counter reset).
- ENABLE dropped at cycle 20000 → no COUNT_VALID and COUNT unchanged. Re-enabling starts a fresh full window.
- MON_CLK held low with the macro defined → ALARM=1 and COUNT_VALID occur 256+1 cycles after the window start. Without the macro → COUNT=0 at cycle 50001.
- RESETN pulsed low mid-window → all outputs 0 immediately. ALARM_CLR on the same cycle as an alarm-setting EVAL → ALARM=1.
